// File: rtl/alu_seq.sv
// alu_seq: registered ALU with single-cycle ops and a shared iterative MUL/DIV/MOD engine.
// Define ALU_SIGNED_EN to make opcode 1111 an arithmetic shift right and SLT a signed compare.
module alu_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int CNT_W   = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [3:0]         cu_aluOp,
  input  logic [WIDTH-1:0]   data1,
  input  logic [WIDTH-1:0]   data2,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   aluOut,
  output logic               zero,
  output logic               negative,
  output logic               div_zero
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  localparam logic [3:0] OP_PASS = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_INC  = 4'b0011;
  localparam logic [3:0] OP_DEC  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_NOT  = 4'b1000;
  localparam logic [3:0] OP_SHL  = 4'b1001;
  localparam logic [3:0] OP_SHR  = 4'b1010;
  localparam logic [3:0] OP_SLT  = 4'b1011;
  localparam logic [3:0] OP_MUL  = 4'b1100;
  localparam logic [3:0] OP_DIV  = 4'b1101;
  localparam logic [3:0] OP_MOD  = 4'b1110;
  localparam logic [3:0] OP_ASR  = 4'b1111;

  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [WIDTH-1:0] alu_op(
    input logic [3:0]         op,
    input logic [WIDTH-1:0]   a,
    input logic [WIDTH-1:0]   b,
    input logic [SHAMT_W-1:0] sh
  );
    logic [WIDTH-1:0] r;
    case (op)
      OP_PASS: r = a;
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_INC:  r = a + ONE_W;
      OP_DEC:  r = a - ONE_W;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOT:  r = ~a;
      OP_SHL:  r = a << sh;
      OP_SHR:  r = a >> sh;
`ifdef ALU_SIGNED_EN
      OP_SLT:  r = ($signed(a) < $signed(b)) ? ONE_W : ZERO_W;
      OP_ASR:  r = WIDTH'($signed(a) >>> sh);
`else
      OP_SLT:  r = (a < b) ? ONE_W : ZERO_W;
      OP_ASR:  r = ZERO_W;
`endif
      default: r = ZERO_W;
    endcase
    return r;
  endfunction

  state_t           state_r, state_n;
  logic [CNT_W-1:0] cnt_r, cnt_n;
  // eng_a: multiplicand / divisor; eng_b: multiplier / quotient; acc: product / remainder
  logic [WIDTH-1:0] eng_a_r, eng_a_n;
  logic [WIDTH-1:0] eng_b_r, eng_b_n;
  logic [WIDTH-1:0] acc_r, acc_n;
  logic             is_mod_r, is_mod_n;
  logic             busy_n, done_n, zero_n, negative_n, div_zero_n;
  logic [WIDTH-1:0] alu_out_n;
  logic             complete_s, dz_s;
  logic [WIDTH-1:0] result_s;
  logic [WIDTH:0]   rem_sh_s;
  logic             rem_ge_s;
  logic [WIDTH-1:0] rem_sub_s;

  // Next-state, engine datapath and result/flag update.
  always_comb begin
    state_n    = state_r;
    cnt_n      = cnt_r;
    eng_a_n    = eng_a_r;
    eng_b_n    = eng_b_r;
    acc_n      = acc_r;
    is_mod_n   = is_mod_r;
    complete_s = 1'b0;
    dz_s       = 1'b0;
    result_s   = ZERO_W;
    rem_sh_s   = {acc_r, eng_b_r[WIDTH-1]};
    rem_ge_s   = (rem_sh_s >= {1'b0, eng_a_r});
    rem_sub_s  = rem_sh_s[WIDTH-1:0] - eng_a_r;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (cu_aluOp == OP_MUL) begin
            eng_a_n = data1;
            eng_b_n = data2;
            acc_n   = ZERO_W;
            cnt_n   = CNT_W'(WIDTH);
            state_n = ST_MUL;
          end else if ((cu_aluOp == OP_DIV) || (cu_aluOp == OP_MOD)) begin
            if (data2 == ZERO_W) begin
              complete_s = 1'b1;
              dz_s       = 1'b1;
              result_s   = (cu_aluOp == OP_DIV) ? ONES_W : data1;
            end else begin
              eng_a_n  = data2;
              eng_b_n  = data1;
              acc_n    = ZERO_W;
              is_mod_n = (cu_aluOp == OP_MOD);
              cnt_n    = CNT_W'(WIDTH);
              state_n  = ST_DIV;
            end
          end else begin
            complete_s = 1'b1;
            result_s   = alu_op(cu_aluOp, data1, data2, shamt);
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_MUL: begin
        acc_n   = acc_r + (eng_b_r[0] ? eng_a_r : ZERO_W);
        eng_a_n = eng_a_r << 1;
        eng_b_n = eng_b_r >> 1;
        cnt_n   = cnt_r - CNT_W'(1);
        if (cnt_r == CNT_W'(1)) begin
          complete_s = 1'b1;
          result_s   = acc_n;
          state_n    = ST_IDLE;
        end else begin
          state_n = ST_MUL;
        end
      end
      ST_DIV: begin
        // Restoring step: keep the shifted remainder when the trial subtract would go negative
        acc_n   = rem_ge_s ? rem_sub_s : rem_sh_s[WIDTH-1:0];
        eng_b_n = {eng_b_r[WIDTH-2:0], rem_ge_s};
        cnt_n   = cnt_r - CNT_W'(1);
        if (cnt_r == CNT_W'(1)) begin
          complete_s = 1'b1;
          result_s   = is_mod_r ? acc_n : eng_b_n;
          state_n    = ST_IDLE;
        end else begin
          state_n = ST_DIV;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    busy_n = (state_n != ST_IDLE);
    if (complete_s) begin
      done_n     = 1'b1;
      alu_out_n  = result_s;
      zero_n     = (result_s == ZERO_W);
      negative_n = result_s[WIDTH-1];
      div_zero_n = dz_s;
    end else begin
      done_n     = 1'b0;
      alu_out_n  = aluOut;
      zero_n     = zero;
      negative_n = negative;
      div_zero_n = div_zero;
    end
  end

  // State, engine and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      eng_a_r  <= ZERO_W;
      eng_b_r  <= ZERO_W;
      acc_r    <= ZERO_W;
      is_mod_r <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      aluOut   <= ZERO_W;
      zero     <= 1'b1;
      negative <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state_r  <= state_n;
      cnt_r    <= cnt_n;
      eng_a_r  <= eng_a_n;
      eng_b_r  <= eng_b_n;
      acc_r    <= acc_n;
      is_mod_r <= is_mod_n;
      busy     <= busy_n;
      done     <= done_n;
      aluOut   <= alu_out_n;
      zero     <= zero_n;
      negative <= negative_n;
      div_zero <= div_zero_n;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=32); expectations follow ALU_SIGNED_EN.
module tb_alu_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  cu_aluOp;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] aluOut;
  logic        zero;
  logic        negative;
  logic        div_zero;

  int n_cmp;
  int n_err;

  alu_seq #(.WIDTH(32), .SHAMT_W(5), .CNT_W(6)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .cu_aluOp (cu_aluOp),
    .data1    (data1),
    .data2    (data2),
    .shamt    (shamt),
    .busy     (busy),
    .done     (done),
    .aluOut   (aluOut),
    .zero     (zero),
    .negative (negative),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    start    = 1'b1;
    cu_aluOp = op;
    data1    = a;
    data2    = b;
    shamt    = sh;
  endtask

  // Returns with time just after the edge that raised done; lat counts cycles from the start edge.
  task automatic wait_done(input bit poke, output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      if (poke && lat < 20) begin
        start = 1'b1;
        cu_aluOp = 4'b0001;
        data1 = 32'h0000_0001;
        data2 = 32'h0000_0001;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    if (lat >= 100) check_value("done_timeout", 32'(lat), 32'd0);
  endtask

  logic [3:0]  v_op [12];
  logic [31:0] v_a  [12];
  logic [31:0] v_b  [12];
  logic [4:0]  v_sh [12];
  logic [31:0] v_exp[12];

  initial begin
    int lat;
    int bc;
    int extra;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    cu_aluOp = 4'd0;
    data1 = 32'd0;
    data2 = 32'd0;
    shamt = 5'd0;

    v_op[0]  = 4'b0000; v_a[0]  = 32'h1234_5678; v_b[0]  = 32'h0;         v_sh[0]  = 5'd0; v_exp[0]  = 32'h1234_5678;
    v_op[1]  = 4'b0010; v_a[1]  = 32'd5;         v_b[1]  = 32'd7;         v_sh[1]  = 5'd0; v_exp[1]  = 32'hFFFF_FFFE;
    v_op[2]  = 4'b0011; v_a[2]  = 32'd7;         v_b[2]  = 32'h0;         v_sh[2]  = 5'd0; v_exp[2]  = 32'd8;
    v_op[3]  = 4'b0100; v_a[3]  = 32'd0;         v_b[3]  = 32'h0;         v_sh[3]  = 5'd0; v_exp[3]  = 32'hFFFF_FFFF;
    v_op[4]  = 4'b0101; v_a[4]  = 32'hF0F0_F0F0; v_b[4]  = 32'hFF00_FF00; v_sh[4]  = 5'd0; v_exp[4]  = 32'hF000_F000;
    v_op[5]  = 4'b0110; v_a[5]  = 32'hF0F0_F0F0; v_b[5]  = 32'h0F0F_0000; v_sh[5]  = 5'd0; v_exp[5]  = 32'hFFFF_F0F0;
    v_op[6]  = 4'b0111; v_a[6]  = 32'hFFFF_0000; v_b[6]  = 32'h0F0F_0F0F; v_sh[6]  = 5'd0; v_exp[6]  = 32'hF0F0_0F0F;
    v_op[7]  = 4'b1000; v_a[7]  = 32'h0000_FFFF; v_b[7]  = 32'h0;         v_sh[7]  = 5'd0; v_exp[7]  = 32'hFFFF_0000;
    v_op[8]  = 4'b1001; v_a[8]  = 32'd3;         v_b[8]  = 32'h0;         v_sh[8]  = 5'd4; v_exp[8]  = 32'h0000_0030;
    v_op[9]  = 4'b1010; v_a[9]  = 32'h8000_0000; v_b[9]  = 32'h0;         v_sh[9]  = 5'd4; v_exp[9]  = 32'h0800_0000;
    v_op[10] = 4'b1011; v_a[10] = 32'd1;         v_b[10] = 32'd2;         v_sh[10] = 5'd0; v_exp[10] = 32'd1;
    v_op[11] = 4'b0001; v_a[11] = 32'd20;        v_b[11] = 32'd22;        v_sh[11] = 5'd0; v_exp[11] = 32'd42;

    repeat (3) @(posedge clk);
    #1;
    check_value("rst_busy", {31'd0, busy}, 32'd0);
    check_value("rst_done", {31'd0, done}, 32'd0);
    check_value("rst_out", aluOut, 32'd0);
    check_value("rst_zero", {31'd0, zero}, 32'd1);
    check_value("rst_neg", {31'd0, negative}, 32'd0);
    check_value("rst_dz", {31'd0, div_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    drive(4'b0001, 32'hFFFF_FFFF, 32'd1, 5'd0);
    wait_done(1'b0, lat, bc);
    check_value("add_lat", 32'(lat), 32'd1);
    check_value("add_out", aluOut, 32'd0);
    check_value("add_zero", {31'd0, zero}, 32'd1);
    check_value("add_neg", {31'd0, negative}, 32'd0);
    @(posedge clk);
    #1;
    check_value("done_pulse_end", {31'd0, done}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      drive(v_op[i], v_a[i], v_b[i], v_sh[i]);
      wait_done(1'b0, lat, bc);
      check_value($sformatf("vec%0d_lat", i), 32'(lat), 32'd1);
      check_value($sformatf("vec%0d_out", i), aluOut, v_exp[i]);
      check_value($sformatf("vec%0d_neg", i), {31'd0, negative}, {31'd0, v_exp[i][31]});
    end

    drive(4'b1100, 32'd12345, 32'd678, 5'd0);
    wait_done(1'b1, lat, bc);
    check_value("mul_lat", 32'(lat), 32'd33);
    check_value("mul_busy_cycles", 32'(bc), 32'd32);
    check_value("mul_out", aluOut, 32'd8369910);
    check_value("mul_busy_end", {31'd0, busy}, 32'd0);
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    check_value("mul_single_done", 32'(extra), 32'd0);
    check_value("mul_hold", aluOut, 32'd8369910);

    drive(4'b1101, 32'd100, 32'd7, 5'd0);
    wait_done(1'b0, lat, bc);
    check_value("div_lat", 32'(lat), 32'd33);
    check_value("div_out", aluOut, 32'd14);
    drive(4'b1110, 32'd100, 32'd7, 5'd0);
    wait_done(1'b0, lat, bc);
    check_value("mod_b2b_lat", 32'(lat), 32'd33);
    check_value("mod_out", aluOut, 32'd2);
    check_value("mod_dz", {31'd0, div_zero}, 32'd0);

    @(negedge clk);
    drive(4'b1101, 32'd55, 32'd0, 5'd0);
    wait_done(1'b0, lat, bc);
    check_value("divz_lat", 32'(lat), 32'd1);
    check_value("divz_out", aluOut, 32'hFFFF_FFFF);
    check_value("divz_dz", {31'd0, div_zero}, 32'd1);
    check_value("divz_neg", {31'd0, negative}, 32'd1);
    drive(4'b1110, 32'd55, 32'd0, 5'd0);
    wait_done(1'b0, lat, bc);
    check_value("modz_out", aluOut, 32'd55);
    check_value("modz_dz", {31'd0, div_zero}, 32'd1);
    drive(4'b0001, 32'd2, 32'd3, 5'd0);
    wait_done(1'b0, lat, bc);
    check_value("dz_clear_out", aluOut, 32'd5);
    check_value("dz_clear", {31'd0, div_zero}, 32'd0);

    drive(4'b1100, 32'd1000, 32'd1000, 5'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_value("abort_busy", {31'd0, busy}, 32'd0);
    check_value("abort_out", aluOut, 32'd0);
    check_value("abort_zero", {31'd0, zero}, 32'd1);
    extra = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    check_value("abort_no_done", 32'(extra), 32'd0);
    drive(4'b1100, 32'd3, 32'd5, 5'd0);
    wait_done(1'b0, lat, bc);
    check_value("mul2_lat", 32'(lat), 32'd33);
    check_value("mul2_out", aluOut, 32'd15);

    drive(4'b1011, 32'hFFFF_FFFF, 32'd1, 5'd0);
    wait_done(1'b0, lat, bc);
`ifdef ALU_SIGNED_EN
    check_value("slt_neg", aluOut, 32'd1);
`else
    check_value("slt_neg", aluOut, 32'd0);
`endif
    drive(4'b1111, 32'h8000_0000, 32'd0, 5'd4);
    wait_done(1'b0, lat, bc);
    check_value("op15_lat", 32'(lat), 32'd1);
`ifdef ALU_SIGNED_EN
    check_value("op15_out", aluOut, 32'hF800_0000);
    check_value("op15_zero", {31'd0, zero}, 32'd0);
`else
    check_value("op15_out", aluOut, 32'd0);
    check_value("op15_zero", {31'd0, zero}, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
